coreb_slave_port: RTL and testbench

//  Slave-side endpoint of the Core-B bus; one instance per decoded slot DnSEL, feeding a peripheral register file (e.g. UART).

---
 rtl/coreb_pkg.sv | 28 ++
 rtl/coreb_slv_lane_dec.sv | 42 ++++
 rtl/coreb_slave_port.sv | 161 ++++++++++++++++
 tb/tb_coreb_slave_port.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/coreb_pkg.sv
// ============================================================================
//  Module  : coreb_pkg
//  Brief   : Shared Core-B slave definitions: widths, size codes, FSM states.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package coreb_pkg;

  localparam int BUS_DW   = 39;
  localparam int REG_DW   = 32;
  localparam int MOD_PRIV = 0;

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DATA = 3'd1,
    ST_RESP = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slv_state_e;

endpackage

`default_nettype wire

// File: rtl/coreb_slv_lane_dec.sv
// ============================================================================
//  Module  : coreb_slv_lane_dec
//  Brief   : Decodes access size, low address bits and mode into byte lanes
//            and an illegal-access flag.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module coreb_slv_lane_dec
  import coreb_pkg::*;
#(
  parameter int PRIV_ONLY = 0
) (
  input  logic [2:0] sz_i,
  input  logic [1:0] addr_lo_i,
  input  logic       priv_i,
  output logic [3:0] be_o,
  output logic       illegal_o
);

  always_comb begin
    be_o      = 4'b0000;
    illegal_o = 1'b0;
    case (sz_i)
      SZ_BYTE: be_o = 4'b0001 << addr_lo_i;
      SZ_HALF: begin
        if (addr_lo_i[0]) illegal_o = 1'b1;
        else              be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: begin
        if (addr_lo_i != 2'b00) illegal_o = 1'b1;
        else                    be_o = 4'b1111;
      end
      default: illegal_o = 1'b1;
    endcase
    // User-mode accesses are refused outright on privileged-only windows
    if ((PRIV_ONLY != 0) && !priv_i) illegal_o = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/coreb_slave_port.sv
// ============================================================================
//  Module  : coreb_slave_port
//  Brief   : Core-B slave endpoint bridging one bus slot to a register file.
//            Optional macro COREB_SLV_TIMEOUT_EN adds a RegAck timeout.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module coreb_slave_port
  import coreb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int PRIV_ONLY   = 0,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              CLK_i,
  input  logic              RST_i,
  input  logic              DSEL_i,
  input  logic              MsRDY_i,
  input  logic              MmWT_i,
  input  logic [2:0]        MmSZ_i,
  input  logic [2:0]        MmMOD_i,
  input  logic [31:0]       MmADDR_i,
  input  logic [BUS_DW-1:0] MmWDT_i,
  output logic              SRDY_o,
  output logic              SERR_o,
  output logic [BUS_DW-1:0] SRDT_o,
  output logic [ADDR_W-1:0] RegAddr_o,
  output logic              RegRd_o,
  output logic              RegWr_o,
  output logic [3:0]        RegBe_o,
  output logic [REG_DW-1:0] RegWrData_o,
  input  logic [REG_DW-1:0] RegRdData_i,
  input  logic              RegAck_i,
  input  logic              RegErr_i
);

  slv_state_e        state_q, state_d;
  logic              wt_q, wt_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [BUS_DW-1:0] srdt_q, srdt_d;
  logic              first_q, first_d;

  logic [3:0]        dec_be;
  logic              dec_illegal;
  logic              accept;

  logic              unused_inputs;
  assign unused_inputs = ^{MmADDR_i[31:ADDR_W], MmMOD_i[2:1], MmWDT_i[BUS_DW-1:REG_DW]};

  coreb_slv_lane_dec #(
    .PRIV_ONLY (PRIV_ONLY)
  ) u_lane_dec (
    .sz_i      (MmSZ_i),
    .addr_lo_i (MmADDR_i[1:0]),
    .priv_i    (MmMOD_i[MOD_PRIV]),
    .be_o      (dec_be),
    .illegal_o (dec_illegal)
  );

  assign accept = DSEL_i & MsRDY_i;

`ifdef COREB_SLV_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_ff @(posedge CLK_i) begin
    if (RST_i) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_q <= ST_IDLE;
      wt_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      srdt_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wt_q    <= wt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      srdt_q  <= srdt_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wt_d    = wt_q;
    addr_d  = addr_q;
    be_d    = be_q;
    srdt_d  = srdt_q;
    first_d = 1'b0;
`ifdef COREB_SLV_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      ST_IDLE, ST_RESP, ST_ERR2: begin
        if (accept) begin
          wt_d   = MmWT_i;
          addr_d = MmADDR_i[ADDR_W-1:2];
          be_d   = dec_be;
          if (dec_illegal) begin
            state_d = ST_ERR1;
            srdt_d  = '0;
          end else begin
            state_d = ST_DATA;
            first_d = 1'b1;
`ifdef COREB_SLV_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (RegAck_i) begin
          if (RegErr_i) begin
            state_d = ST_ERR1;
            srdt_d  = '0;
          end else begin
            state_d = ST_RESP;
            srdt_d  = wt_q ? '0 : {{(BUS_DW-REG_DW){1'b0}}, RegRdData_i};
          end
        end else begin
`ifdef COREB_SLV_TIMEOUT_EN
          // Strobe is never re-issued; a late ack lands outside DATA and is dropped
          if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            state_d = ST_ERR1;
            srdt_d  = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
`endif
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  assign SRDY_o      = (state_q == ST_IDLE) || (state_q == ST_RESP) || (state_q == ST_ERR2);
  assign SERR_o      = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign SRDT_o      = srdt_q;
  assign RegAddr_o   = {addr_q, 2'b00};
  assign RegBe_o     = be_q;
  assign RegRd_o     = (state_q == ST_DATA) && first_q && !wt_q;
  assign RegWr_o     = (state_q == ST_DATA) && first_q && wt_q;
  assign RegWrData_o = MmWDT_i[REG_DW-1:0];

endmodule

`default_nettype wire

// File: tb/tb_coreb_slave_port.sv
// ============================================================================
//  Module  : tb_coreb_slave_port
//  Brief   : Scoreboard bench for coreb_slave_port.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_coreb_slave_port;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        DSEL = 1'b0, DSEL_P = 1'b0, MsRDY = 1'b0, MmWT = 1'b0;
  logic [2:0]  MmSZ = 3'b000, MmMOD = 3'b000;
  logic [31:0] MmADDR = 32'h0;
  logic [38:0] MmWDT = 39'h0;
  logic [31:0] RegRdData = 32'h0;
  logic        RegAck = 1'b0, RegErr = 1'b0, RegAck_P = 1'b0;

  logic        SRDY, SERR, RegRd, RegWr;
  logic [38:0] SRDT;
  logic [7:0]  RegAddr;
  logic [3:0]  RegBe;
  logic [31:0] RegWrData;

  logic        p_SRDY, p_SERR, p_RegRd, p_RegWr;
  logic [38:0] p_SRDT;
  logic [7:0]  p_RegAddr;
  logic [3:0]  p_RegBe;
  logic [31:0] p_RegWrData;

  typedef struct {
    logic [38:0] rdt;
    logic        err;
  } resp_t;
  resp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  logic prev_srdy = 1'b1;

  always #5 CLK = ~CLK;

  coreb_slave_port u_dut (
    .CLK_i(CLK), .RST_i(RST), .DSEL_i(DSEL), .MsRDY_i(MsRDY), .MmWT_i(MmWT),
    .MmSZ_i(MmSZ), .MmMOD_i(MmMOD), .MmADDR_i(MmADDR), .MmWDT_i(MmWDT),
    .SRDY_o(SRDY), .SERR_o(SERR), .SRDT_o(SRDT), .RegAddr_o(RegAddr),
    .RegRd_o(RegRd), .RegWr_o(RegWr), .RegBe_o(RegBe), .RegWrData_o(RegWrData),
    .RegRdData_i(RegRdData), .RegAck_i(RegAck), .RegErr_i(RegErr)
  );

  coreb_slave_port #(.PRIV_ONLY(1)) u_dut_priv (
    .CLK_i(CLK), .RST_i(RST), .DSEL_i(DSEL_P), .MsRDY_i(MsRDY), .MmWT_i(MmWT),
    .MmSZ_i(MmSZ), .MmMOD_i(MmMOD), .MmADDR_i(MmADDR), .MmWDT_i(MmWDT),
    .SRDY_o(p_SRDY), .SERR_o(p_SERR), .SRDT_o(p_SRDT), .RegAddr_o(p_RegAddr),
    .RegRd_o(p_RegRd), .RegWr_o(p_RegWr), .RegBe_o(p_RegBe), .RegWrData_o(p_RegWrData),
    .RegRdData_i(RegRdData), .RegAck_i(RegAck_P), .RegErr_i(1'b0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Completion = SRDY rising; the oldest outstanding expectation is retired
  always @(negedge CLK) begin
    if (SRDY && !prev_srdy && exp_q.size() > 0) begin
      chk("resp_err", {63'b0, SERR}, {63'b0, exp_q[0].err});
      chk("resp_rdt", {25'b0, SRDT}, {25'b0, exp_q[0].rdt});
      exp_q.delete(0);
    end
    prev_srdy <= SRDY;
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic addr_phase(input logic wt, input logic [2:0] sz, input logic [2:0] md,
                            input logic [31:0] a);
    DSEL = 1'b1; MsRDY = 1'b1; MmWT = wt; MmSZ = sz; MmMOD = md; MmADDR = a;
    cyc();
    DSEL = 1'b0; MsRDY = 1'b0;
  endtask

  task automatic push(input logic [38:0] rdt, input logic err);
    resp_t r;
    r.rdt = rdt;
    r.err = err;
    exp_q.push_back(r);
  endtask

  initial begin
    int lowcnt;
    int wrcnt;

    repeat (2) cyc();
    chk("rst_srdy", {63'b0, SRDY}, 64'd1);
    chk("rst_serr", {63'b0, SERR}, 64'd0);
    chk("rst_srdt", {25'b0, SRDT}, 64'd0);
    chk("rst_rd",   {63'b0, RegRd}, 64'd0);
    chk("rst_wr",   {63'b0, RegWr}, 64'd0);
    chk("rst_addr", {56'b0, RegAddr}, 64'd0);
    chk("rst_be",   {60'b0, RegBe}, 64'd0);
    RST = 1'b0;
    cyc();

    // Word read, ack coincides with strobe
    push(39'h00A5A51234, 1'b0);
    addr_phase(1'b0, 3'b010, 3'b001, 32'h4000_0010);
    chk("t1_rd",   {63'b0, RegRd}, 64'd1);
    chk("t1_wr",   {63'b0, RegWr}, 64'd0);
    chk("t1_addr", {56'b0, RegAddr}, 64'h10);
    chk("t1_be",   {60'b0, RegBe}, 64'hF);
    chk("t1_wait", {63'b0, SRDY}, 64'd0);
    RegAck = 1'b1; RegRdData = 32'hA5A5_1234;
    cyc();
    RegAck = 1'b0; RegRdData = 32'hDEAD_0000;
    chk("t1_srdy", {63'b0, SRDY}, 64'd1);
    cyc();
    chk("t1_hold", {25'b0, SRDT}, 64'h00A5A51234);
    chk("t1_once", {63'b0, RegRd}, 64'd0);

    // Byte write 0x07, user mode on non-priv slot, ack three cycles after strobe
    push(39'h0, 1'b0);
    MmWDT = 39'h7F_1122_3344;
    addr_phase(1'b1, 3'b000, 3'b000, 32'h0000_0007);
    chk("t2_be",    {60'b0, RegBe}, 64'h8);
    chk("t2_addr",  {56'b0, RegAddr}, 64'h04);
    chk("t2_wdata", {32'b0, RegWrData}, 64'h11223344);
    chk("t2_rd",    {63'b0, RegRd}, 64'd0);
    lowcnt = 0; wrcnt = 0;
    for (int i = 0; i < 4; i++) begin
      lowcnt += (SRDY ? 0 : 1);
      wrcnt  += (RegWr ? 1 : 0);
      if (i == 3) RegAck = 1'b1;
      cyc();
    end
    RegAck = 1'b0; MmWDT = 39'h0;
    chk("t2_lowcnt", 64'(lowcnt), 64'd4);
    chk("t2_wrcnt",  64'(wrcnt), 64'd1);
    chk("t2_srdy",   {63'b0, SRDY}, 64'd1);
    chk("t2_srdt",   {25'b0, SRDT}, 64'd0);
    cyc();

    // Misaligned half -> two-cycle error, no strobe
    push(39'h0, 1'b1);
    addr_phase(1'b0, 3'b001, 3'b001, 32'h0000_0003);
    chk("t3_e1_rdy", {63'b0, SRDY}, 64'd0);
    chk("t3_e1_err", {63'b0, SERR}, 64'd1);
    chk("t3_strobe", {62'b0, RegRd, RegWr}, 64'd0);
    cyc();
    chk("t3_e2_rdy", {63'b0, SRDY}, 64'd1);
    chk("t3_e2_err", {63'b0, SERR}, 64'd1);
    cyc();
    chk("t3_idle_err", {63'b0, SERR}, 64'd0);

    // RegErr on read, then back-to-back from ERR2 and from RESP
    push(39'h0, 1'b1);
    addr_phase(1'b0, 3'b010, 3'b001, 32'h0000_0020);
    chk("t4_rd", {63'b0, RegRd}, 64'd1);
    RegAck = 1'b1; RegErr = 1'b1; RegRdData = 32'h1234_5678;
    cyc();
    RegAck = 1'b0; RegErr = 1'b0;
    chk("t4_e1_err",  {63'b0, SERR}, 64'd1);
    chk("t4_e1_srdt", {25'b0, SRDT}, 64'd0);
    cyc();
    chk("t4_e2_rdy", {63'b0, SRDY}, 64'd1);
    push(39'h00CAFEBEEF, 1'b0);
    addr_phase(1'b0, 3'b001, 3'b001, 32'h0000_0022);
    chk("t4_b2b_rd", {63'b0, RegRd}, 64'd1);
    chk("t4_b2b_be", {60'b0, RegBe}, 64'hC);
    RegAck = 1'b1; RegRdData = 32'hCAFE_BEEF;
    cyc();
    RegAck = 1'b0;
    push(39'h0000AB0000, 1'b0);
    addr_phase(1'b0, 3'b000, 3'b001, 32'h0000_0001);
    chk("t4_resp_b2b_be", {60'b0, RegBe}, 64'h2);
    RegAck = 1'b1; RegRdData = 32'h00AB_0000;
    cyc();
    RegAck = 1'b0;
    cyc();

    // Illegal size code and misaligned word write
    push(39'h0, 1'b1);
    addr_phase(1'b0, 3'b011, 3'b001, 32'h0000_0000);
    chk("t5_sz_err", {63'b0, SERR}, 64'd1);
    cyc(); cyc();
    push(39'h0, 1'b1);
    addr_phase(1'b1, 3'b010, 3'b001, 32'h0000_0002);
    chk("t5_mis_wr",  {63'b0, RegWr}, 64'd0);
    chk("t5_mis_err", {63'b0, SERR}, 64'd1);
    cyc(); cyc();

    // No ack: timeout or indefinite wait
`ifdef COREB_SLV_TIMEOUT_EN
    push(39'h0, 1'b1);
    addr_phase(1'b0, 3'b010, 3'b001, 32'h0000_0030);
    lowcnt = 0;
    for (int i = 0; i < 15; i++) begin
      lowcnt += (!SRDY && !SERR) ? 1 : 0;
      cyc();
    end
    chk("t6_wait", 64'(lowcnt), 64'd15);
    chk("t6_last_data", {62'b0, SRDY, SERR}, 64'd0);
    cyc();
    chk("t6_tmo_err", {62'b0, SRDY, SERR}, 64'd1);
    RegAck = 1'b1; RegRdData = 32'h0000_0777;
    cyc();
    RegAck = 1'b0;
    chk("t6_e2", {62'b0, SRDY, SERR}, 64'd3);
    cyc();
`else
    push(39'h0000000777, 1'b0);
    addr_phase(1'b0, 3'b010, 3'b001, 32'h0000_0030);
    lowcnt = 0;
    for (int i = 0; i < 20; i++) begin
      lowcnt += (!SRDY && !SERR) ? 1 : 0;
      cyc();
    end
    chk("t6_wait", 64'(lowcnt), 64'd20);
    RegAck = 1'b1; RegRdData = 32'h0000_0777;
    cyc();
    RegAck = 1'b0;
    chk("t6_srdy", {63'b0, SRDY}, 64'd1);
    cyc();
`endif

    // Reset in the middle of a write
    addr_phase(1'b1, 3'b010, 3'b001, 32'h0000_0040);
    chk("t7_wr", {63'b0, RegWr}, 64'd1);
    RST = 1'b1;
    cyc();
    chk("t7_srdy", {63'b0, SRDY}, 64'd1);
    chk("t7_serr", {63'b0, SERR}, 64'd0);
    chk("t7_strb", {62'b0, RegRd, RegWr}, 64'd0);
    RST = 1'b0;
    cyc();
    push(39'h0000000042, 1'b0);
    addr_phase(1'b0, 3'b010, 3'b001, 32'h0000_0044);
    chk("t7_after_rd", {63'b0, RegRd}, 64'd1);
    RegAck = 1'b1; RegRdData = 32'h0000_0042;
    cyc();
    RegAck = 1'b0;
    cyc();

    // Privileged-only slot: user access errors, privileged access strobes
    DSEL_P = 1'b1; MsRDY = 1'b1; MmWT = 1'b0; MmSZ = 3'b010; MmMOD = 3'b000; MmADDR = 32'h0;
    cyc();
    DSEL_P = 1'b0; MsRDY = 1'b0;
    chk("t8_user_err", {62'b0, p_SRDY, p_SERR}, 64'd1);
    chk("t8_user_rd",  {63'b0, p_RegRd}, 64'd0);
    cyc();
    chk("t8_user_e2", {62'b0, p_SRDY, p_SERR}, 64'd3);
    DSEL_P = 1'b1; MsRDY = 1'b1; MmMOD = 3'b001;
    cyc();
    DSEL_P = 1'b0; MsRDY = 1'b0;
    chk("t8_priv_rd", {63'b0, p_RegRd}, 64'd1);
    RegAck_P = 1'b1;
    cyc();
    RegAck_P = 1'b0;
    chk("t8_priv_ok", {62'b0, p_SRDY, p_SERR}, 64'd2);
    cyc(); cyc();

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
